// File: rtl/clsf_forest_engine.sv
// clsf_forest_engine: time-multiplexed binary decision-forest classifier.
// A writable node table holds NUM_TREES trees of 2^NODE_AW nodes each.
// Each accepted feature vector is walked through every tree in order. One
// node costs a FETCH cycle (table read) plus an EVAL cycle (decode/branch).
//
// Handshake rule on both sides: a transfer happens on a rising edge where
// valid and ready are both 1. The producer must hold data while valid is 1
// and ready is 0. The result side holds every result output stable from
// result_valid rising until the edge where result_ready is also 1.
module clsf_forest_engine #(
  parameter int IN_WIDTH  = 576,
  parameter int NUM_TREES = 8,
  parameter int NODE_AW   = 6,
  parameter int MAX_DEPTH = 5,
  localparam int TREE_W   = $clog2(NUM_TREES),
  localparam int IDX_W    = $clog2(IN_WIDTH + 1),
  localparam int NODE_W   = 2 + IDX_W + 2 * NODE_AW,
  localparam int CNT_W    = $clog2(NUM_TREES + 1),
  localparam int ADDR_W   = TREE_W + NODE_AW
) (
  input  logic                 rx_fifo_clock,
  input  logic                 rx_fifo_reset,
  input  logic [IN_WIDTH-1:0]  data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic [NUM_TREES-1:0] result_data,
  output logic [NUM_TREES-1:0] depth_err,
  output logic [CNT_W-1:0]     vote_count,
  output logic                 vote_major,
  output logic                 result_valid,
  input  logic                 result_ready,
  input  logic                 cfg_we,
  input  logic [ADDR_W-1:0]    cfg_addr,
  input  logic [NODE_W-1:0]    cfg_wdata,
  output logic                 cfg_ready
);

  localparam int DEPTH_W   = ($clog2(MAX_DEPTH + 1) < 1) ? 1 : $clog2(MAX_DEPTH + 1);
  localparam int NUM_WORDS = NUM_TREES * (2 ** NODE_AW);

  localparam logic [DEPTH_W-1:0] DEPTH_LIMIT = DEPTH_W'(MAX_DEPTH);
  localparam logic [TREE_W-1:0]  LAST_TREE   = TREE_W'(NUM_TREES - 1);
  localparam logic [IDX_W-1:0]   IDX_MAX     = IDX_W'(IN_WIDTH);
  localparam logic [CNT_W:0]     MAJ_THRESH  = (CNT_W + 1)'(NUM_TREES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EVAL  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Node word field positions: {is_leaf, leaf_val, bit_idx, left, right}
  localparam int RIGHT_LSB = 0;
  localparam int LEFT_LSB  = NODE_AW;
  localparam int IDX_LSB   = 2 * NODE_AW;
  localparam int LVAL_BIT  = 2 * NODE_AW + IDX_W;
  localparam int LEAF_BIT  = 2 * NODE_AW + IDX_W + 1;

  state_t                state_q, state_d;
  logic [TREE_W-1:0]     tree_q, tree_d;
  logic [NODE_AW-1:0]    node_q, node_d;
  logic [DEPTH_W-1:0]    depth_q, depth_d;
  logic [NUM_TREES-1:0]  result_q, result_d;
  logic [NUM_TREES-1:0]  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  major_q, major_d;
  logic                  valid_q, valid_d;

  logic [IN_WIDTH-1:0]   data_q;
  logic                  capture;
  logic                  mem_re;
  logic                  mem_we;

  logic [NODE_W-1:0]     node_mem [NUM_WORDS];
  logic [NODE_W-1:0]     rd_word_q;

  // Decoded fields of the word returned by the table
  logic                  w_is_leaf;
  logic                  w_leaf_val;
  logic [IDX_W-1:0]      w_bit_idx;
  logic [NODE_AW-1:0]    w_left;
  logic [NODE_AW-1:0]    w_right;
  logic [IN_WIDTH:0]     feat_ext;
  logic                  feat_bit;
  logic                  tree_end;
  logic [CNT_W-1:0]      cnt_next;

  assign w_is_leaf  = rd_word_q[LEAF_BIT];
  assign w_leaf_val = rd_word_q[LVAL_BIT];
  assign w_bit_idx  = rd_word_q[IDX_LSB +: IDX_W];
  assign w_left     = rd_word_q[LEFT_LSB +: NODE_AW];
  assign w_right    = rd_word_q[RIGHT_LSB +: NODE_AW];

  // Feature position 0 is a constant 0, so index k maps directly to feat_ext[k]
  assign feat_ext = {data_q, 1'b0};

  // Select the tested feature bit; indices past the vector read as 0
  always_comb begin
    feat_bit = 1'b0;
    if (w_bit_idx <= IDX_MAX) begin
      feat_bit = feat_ext[w_bit_idx];
    end
  end

  // Current tree finishes on a leaf or on a non-leaf at the depth limit
  assign tree_end = w_is_leaf || (depth_q == DEPTH_LIMIT);
  assign cnt_next = cnt_q + CNT_W'(w_is_leaf & w_leaf_val);

  // Table writes only while idle and out of reset
  assign mem_we     = cfg_we && (state_q == S_IDLE) && !rx_fifo_reset;
  assign data_ready = (state_q == S_IDLE) && !rx_fifo_reset;
  assign cfg_ready  = (state_q == S_IDLE) && !rx_fifo_reset;

  // Node table: synchronous write and 1-cycle read, never reset
  always_ff @(posedge rx_fifo_clock) begin
    if (mem_we) begin
      node_mem[cfg_addr] <= cfg_wdata;
    end
    if (mem_re) begin
      rd_word_q <= node_mem[{tree_q, node_q}];
    end
  end

  // Feature vector capture register; frozen for the whole evaluation
  always_ff @(posedge rx_fifo_clock) begin
    if (capture) begin
      data_q <= data_in;
    end
  end

  // Next-state and datapath updates of the evaluation FSM
  always_comb begin
    state_d  = state_q;
    tree_d   = tree_q;
    node_d   = node_q;
    depth_d  = depth_q;
    result_d = result_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    major_d  = major_q;
    valid_d  = valid_q;
    capture  = 1'b0;
    mem_re   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (data_valid) begin
          capture  = 1'b1;
          result_d = '0;
          err_d    = '0;
          cnt_d    = '0;
          tree_d   = '0;
          node_d   = '0;
          depth_d  = '0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_re  = 1'b1;
        state_d = S_EVAL;
      end
      S_EVAL: begin
        if (tree_end) begin
          // A depth overrun forces the tree result to 0 and flags it
          result_d[tree_q] = w_is_leaf & w_leaf_val;
          err_d[tree_q]    = ~w_is_leaf;
          cnt_d            = cnt_next;
          if (tree_q == LAST_TREE) begin
            major_d = ({cnt_next, 1'b0} > MAJ_THRESH);
            valid_d = 1'b1;
            state_d = S_DONE;
          end else begin
            tree_d  = tree_q + 1'b1;
            node_d  = '0;
            depth_d = '0;
            state_d = S_FETCH;
          end
        end else begin
          node_d  = feat_bit ? w_right : w_left;
          depth_d = depth_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        if (result_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers; reset discards any partial evaluation
  always_ff @(posedge rx_fifo_clock or posedge rx_fifo_reset) begin
    if (rx_fifo_reset) begin
      state_q  <= S_IDLE;
      tree_q   <= '0;
      node_q   <= '0;
      depth_q  <= '0;
      result_q <= '0;
      err_q    <= '0;
      cnt_q    <= '0;
      major_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tree_q   <= tree_d;
      node_q   <= node_d;
      depth_q  <= depth_d;
      result_q <= result_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      major_q  <= major_d;
      valid_q  <= valid_d;
    end
  end

  assign result_data  = result_q;
  assign depth_err    = err_q;
  assign vote_count   = cnt_q;
  assign vote_major   = major_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_clsf_forest_engine.sv
// Directed bench for clsf_forest_engine with default parameters
// (576-bit vectors, 8 trees, 64 nodes per tree, depth limit 5).
module tb_clsf_forest_engine;

  localparam int IN_WIDTH = 576;
  localparam int NT       = 8;
  localparam int NODE_W   = 24;
  localparam int CNT_W    = 4;
  localparam int ADDR_W   = 9;

  logic                clk;
  logic                rst;
  logic [IN_WIDTH-1:0] data_in;
  logic                data_valid;
  logic                data_ready;
  logic [NT-1:0]       result_data;
  logic [NT-1:0]       depth_err;
  logic [CNT_W-1:0]    vote_count;
  logic                vote_major;
  logic                result_valid;
  logic                result_ready;
  logic                cfg_we;
  logic [ADDR_W-1:0]   cfg_addr;
  logic [NODE_W-1:0]   cfg_wdata;
  logic                cfg_ready;

  int n_total = 0;
  int n_bad   = 0;

  clsf_forest_engine dut (
    .rx_fifo_clock (clk),
    .rx_fifo_reset (rst),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .result_data   (result_data),
    .depth_err     (depth_err),
    .vote_count    (vote_count),
    .vote_major    (vote_major),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .cfg_ready     (cfg_ready)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NODE_W-1:0] leaf(input logic v);
    return {1'b1, v, 10'd0, 6'd0, 6'd0};
  endfunction

  function automatic logic [NODE_W-1:0] inner(input logic [9:0] idx, input logic [5:0] l,
                                              input logic [5:0] r);
    return {1'b0, 1'b0, idx, l, r};
  endfunction

  task automatic cfg_write(input int tree, input int node, input logic [NODE_W-1:0] w);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = {tree[2:0], node[5:0]};
    cfg_wdata = w;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  // Accept one vector, wait for result_valid, check results and latency.
  // Latency counts cycles from the accepting edge to the first edge where
  // result_valid is sampled high. data_in is scrambled right after capture.
  task automatic run(input string tag, input logic [IN_WIDTH-1:0] vec,
                     input logic [NT-1:0] exp_res, input logic [NT-1:0] exp_err,
                     input int exp_cnt, input logic exp_major, input int exp_lat,
                     input bit do_ack);
    int cnt;
    @(negedge clk);
    chk({tag, ".ready_in"}, data_ready, 1'b1);
    data_in    = vec;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    data_in    = ~vec;
    cnt = 1;
    while (!result_valid && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, ".latency"}, cnt, exp_lat);
    chk({tag, ".result"}, result_data, exp_res);
    chk({tag, ".deptherr"}, depth_err, exp_err);
    chk({tag, ".votes"}, vote_count, exp_cnt);
    chk({tag, ".major"}, vote_major, exp_major);
    if (do_ack) begin
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      chk({tag, ".valid_drop"}, result_valid, 1'b0);
      chk({tag, ".idle_ready"}, data_ready, 1'b1);
    end
  endtask

  initial begin
    logic [IN_WIDTH-1:0] v;
    logic [IN_WIDTH-1:0] scramble;
    int cnt;

    rst          = 1'b1;
    data_in      = '0;
    data_valid   = 1'b0;
    result_ready = 1'b0;
    cfg_we       = 1'b0;
    cfg_addr     = '0;
    cfg_wdata    = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst.valid", result_valid, 1'b0);
    chk("rst.result", result_data, '0);
    chk("rst.deptherr", depth_err, '0);
    chk("rst.votes", vote_count, '0);
    chk("rst.major", vote_major, 1'b0);
    chk("rst.data_ready", data_ready, 1'b0);
    chk("rst.cfg_ready", cfg_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst.data_ready", data_ready, 1'b1);
    chk("post_rst.cfg_ready", cfg_ready, 1'b1);

    // All roots leaves with leaf_val = t[0]: 0xAA, tie -> no majority
    for (int t = 0; t < NT; t++) cfg_write(t, 0, leaf(t[0]));
    v = '0;
    run("leafroots", v, 8'hAA, 8'h00, 4, 1'b0, 17, 1'b1);

    // Reset during tree 4 (cycles 9/10 after accept), then rerun
    @(negedge clk);
    data_in    = '1;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst.result", result_data, '0);
    chk("midrst.votes", vote_count, '0);
    chk("midrst.valid", result_valid, 1'b0);
    chk("midrst.data_ready", data_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst.cfg_ready", cfg_ready, 1'b1);
    run("rerun", '1, 8'hAA, 8'h00, 4, 1'b0, 17, 1'b1);

    // Tree 0 tests bit_idx = 1; other trees are leaf 1
    cfg_write(0, 0, inner(10'd1, 6'd1, 6'd2));
    cfg_write(0, 1, leaf(1'b0));
    cfg_write(0, 2, leaf(1'b1));
    for (int t = 1; t < NT; t++) cfg_write(t, 0, leaf(1'b1));
    v = '0; v[0] = 1'b1;
    run("bit1_one", v, 8'hFF, 8'h00, 8, 1'b1, 19, 1'b1);
    v = '0;
    run("bit1_zero", v, 8'hFE, 8'h00, 7, 1'b1, 19, 1'b1);
    v = '0; v[1] = 1'b1;
    run("bit1_neighbor", v, 8'hFE, 8'h00, 7, 1'b1, 19, 1'b1);

    // bit_idx 0 is constant 0
    cfg_write(0, 0, inner(10'd0, 6'd1, 6'd2));
    run("bit0_const", '1, 8'hFE, 8'h00, 7, 1'b1, 19, 1'b1);

    // Top index 576 reads data_in[575]
    cfg_write(0, 0, inner(10'd576, 6'd1, 6'd2));
    v = '0; v[575] = 1'b1;
    run("bit576", v, 8'hFF, 8'h00, 8, 1'b1, 19, 1'b1);

    // Index beyond the vector reads 0
    cfg_write(0, 0, inner(10'd577, 6'd1, 6'd2));
    run("bit577", '1, 8'hFE, 8'h00, 7, 1'b1, 19, 1'b1);

    // Result held under backpressure; input and cfg strobes ignored
    cfg_write(0, 0, inner(10'd1, 6'd1, 6'd2));
    v = '0; v[0] = 1'b1;
    run("hold", v, 8'hFF, 8'h00, 8, 1'b1, 19, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      scramble   = {18{$urandom()}};
      data_in    = scramble;
      data_valid = (i % 2) == 0;
      cfg_we     = 1'b1;
      cfg_addr   = {3'd1, 6'd0};
      cfg_wdata  = leaf(1'b0);
      chk("hold.valid", result_valid, 1'b1);
      chk("hold.result", result_data, 8'hFF);
      chk("hold.votes", vote_count, 8);
      chk("hold.major", vote_major, 1'b1);
      chk("hold.data_ready", data_ready, 1'b0);
      chk("hold.cfg_ready", cfg_ready, 1'b0);
    end
    @(negedge clk);
    data_valid   = 1'b0;
    cfg_we       = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk("hold.release_valid", result_valid, 1'b0);
    chk("hold.release_ready", data_ready, 1'b1);
    repeat (3) @(negedge clk);
    chk("hold.no_capture", result_valid, 1'b0);
    chk("hold.no_capture_ready", data_ready, 1'b1);
    run("hold_rerun", v, 8'hFF, 8'h00, 8, 1'b1, 19, 1'b1);

    // Tree 3 self-loop runs into the depth limit
    cfg_write(0, 0, leaf(1'b1));
    cfg_write(3, 0, inner(10'd0, 6'd0, 6'd0));
    run("selfloop", '0, 8'hF7, 8'h08, 7, 1'b1, 27, 1'b1);

    // Depth error clears on the next accepted vector
    cfg_write(3, 0, leaf(1'b1));
    run("after_loop", '0, 8'hFF, 8'h00, 8, 1'b1, 17, 1'b1);

    // Bounded wait sanity: no spurious result without input
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (result_valid) cnt++;
    end
    chk("quiet", cnt, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
